// File: rtl/status_display_driver_if.sv
// Status-code and panel signals between the priority controller
// side and the front-panel display driver.
interface status_display_driver_if;
  logic [2:0] display;
  logic       lamp_test;
  logic [6:0] seg;
  logic [3:0] an;
  logic [2:0] msg_code;
  logic       msg_update;

  modport master (
    output display, lamp_test,
    input  seg, an, msg_code, msg_update
  );

  modport slave (
    input  display, lamp_test,
    output seg, an, msg_code, msg_update
  );
endinterface

// File: rtl/status_display_driver.sv
// Front-panel driver: status code to 4-digit multiplexed 7-segment
// message, with hold time, urgent pre-emption and fire blink.
module status_display_driver #(
  parameter int SCAN_DIV    = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int BLINK_DIV   = 32
) (
  input logic                   clk,
  input logic                   rst,
  status_display_driver_if.slave io
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [2:0] FIRE = 3'd3;

  logic [2:0]    disp_q;
  logic [2:0]    msg_code;
  logic          msg_update;
  logic [HW-1:0] hold;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;
  logic [6:0]    seg;
  logic [3:0]    an;

  logic          urgent;
  logic          load;
  logic [6:0]    glyph;
  logic [27:0]   row;

  assign urgent = (disp_q != 3'd0) && (disp_q <= 3'd3);
  assign load   = (disp_q != msg_code) &&
                  ((hold == '0) || urgent);

  // Row packs the glyphs for digits 3..0, digit 0 lowest.
  always_comb begin
    row = '0;
    unique case (msg_code)
      3'd0: row = {7'h06, 7'h5E, 7'h38, 7'h79};
      3'd1: row = {7'h71, 7'h5E, 7'h50, 7'h00};
      3'd2: row = {7'h50, 7'h5E, 7'h50, 7'h00};
      3'd3: row = {7'h71, 7'h06, 7'h50, 7'h79};
      3'd4: row = {7'h3E, 7'h06, 7'h54, 7'h5E};
      3'd5: row = {7'h76, 7'h79, 7'h77, 7'h78};
      3'd6: row = {7'h39, 7'h3F, 7'h3F, 7'h38};
      3'd7: row = {7'h79, 7'h50, 7'h50, 7'h00};
    endcase
  end

  always_comb begin
    glyph = '0;
    unique case (idx)
      2'd0: glyph = row[6:0];
      2'd1: glyph = row[13:7];
      2'd2: glyph = row[20:14];
      2'd3: glyph = row[27:21];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_q     <= '0;
      msg_code   <= '0;
      msg_update <= 1'b0;
      hold       <= '0;
    end else begin
      disp_q <= io.display;
      if (load) begin
        msg_code   <= disp_q;
        hold       <= HOLD_LAST;
        msg_update <= 1'b1;
      end else begin
        msg_update <= 1'b0;
        if (hold != '0) hold <= hold - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // A fresh fire message always starts in the visible phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (load && (disp_q == FIRE)) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= '0;
      an  <= '0;
    end else if (io.lamp_test) begin
      seg <= 7'h7F;
      an  <= 4'hF;
    end else begin
      seg <= glyph;
      if ((msg_code == FIRE) && blink_off)
        an <= 4'h0;
      else
        an <= 4'b0001 << idx;
    end
  end

  assign io.seg        = seg;
  assign io.an         = an;
  assign io.msg_code   = msg_code;
  assign io.msg_update = msg_update;

endmodule

// File: tb/tb_status_display_driver.sv
// Bench for status_display_driver: directed scenarios plus random
// codes, checked against a time-based reference model.
module tb_status_display_driver;

  localparam int SD = 4;
  localparam int HC = 16;
  localparam int BD = 32;

  // Glyphs indexed [code][digit], digit 0 rightmost.
  localparam logic [6:0] GL [8][4] = '{
    '{7'h79, 7'h38, 7'h5E, 7'h06},
    '{7'h00, 7'h50, 7'h5E, 7'h71},
    '{7'h00, 7'h50, 7'h5E, 7'h50},
    '{7'h79, 7'h50, 7'h06, 7'h71},
    '{7'h5E, 7'h54, 7'h06, 7'h3E},
    '{7'h78, 7'h77, 7'h79, 7'h76},
    '{7'h38, 7'h3F, 7'h3F, 7'h39},
    '{7'h00, 7'h50, 7'h50, 7'h79}
  };

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  status_display_driver_if io ();

  status_display_driver #(
    .SCAN_DIV   (SD),
    .HOLD_CYCLES(HC),
    .BLINK_DIV  (BD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int pulses;

  // Model: edge count since reset, cycle of last fire load.
  int         t;
  int         origin;
  logic [2:0] m_disp;
  logic [2:0] m_code;
  int         m_hold;
  bit         m_off;

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h",
             tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_disp = '0;
    m_code = '0;
    m_hold = 0;
    t      = 0;
    origin = 0;
  endtask

  task automatic step();
    logic [2:0] d;
    logic       lt;
    logic [6:0] es;
    logic [3:0] ea;
    logic       eu;
    int         ix;
    d  = io.display;
    lt = io.lamp_test;
    @(posedge clk);
    #1;
    t++;
    ix    = ((t - 1) / SD) % 4;
    m_off = (((t - 1 - origin) / BD) % 2) == 1;
    es = lt ? 7'h7F : GL[m_code][ix];
    if (lt)
      ea = 4'hF;
    else if (m_code == 3'd3 && m_off)
      ea = 4'h0;
    else
      ea = 4'(1 << ix);
    eu = (m_disp != m_code) &&
         (m_hold == 0 || m_disp inside {3'd1, 3'd2, 3'd3});
    if (eu) begin
      m_code = m_disp;
      m_hold = HC - 1;
      if (m_disp == 3'd3) origin = t;
    end else if (m_hold > 0) begin
      m_hold--;
    end
    m_disp = d;
    if (io.msg_update === 1'b1) pulses++;
    check("seg", 8'(io.seg), 8'(es));
    check("an", 8'(io.an), 8'(ea));
    check("msg_code", 8'(io.msg_code), 8'(m_code));
    check("msg_update", 8'(io.msg_update), 8'(eu));
  endtask

  initial begin
    io.display   = 3'd0;
    io.lamp_test = 1'b0;
    pulses       = 0;
    model_reset();
    #1;
    check("rst_seg", 8'(io.seg), 8'h00);
    check("rst_an", 8'(io.an), 8'h00);
    check("rst_code", 8'(io.msg_code), 8'h00);
    check("rst_upd", 8'(io.msg_update), 8'h00);
    #12 rst = 1'b1;

    // Idle scan after reset release.
    step();
    check("first_an", 8'(io.an), 8'h01);
    check("first_seg", 8'(io.seg), 8'h79);
    for (int i = 0; i < 16; i++) step();

    // Non-urgent change, then a second one held off.
    io.display = 3'd5;
    step();
    step();
    check("heat_pulse", 8'(io.msg_update), 8'h01);
    check("heat_code", 8'(io.msg_code), 8'h05);
    for (int e = 3; e <= 17; e++) begin
      if (e == 6) io.display = 3'd6;
      step();
    end
    check("held_code", 8'(io.msg_code), 8'h05);
    step();
    check("cool_code", 8'(io.msg_code), 8'h06);

    // Fire pre-empts an active hold and blinks.
    io.display = 3'd3;
    step();
    step();
    check("fire_code", 8'(io.msg_code), 8'h03);
    for (int i = 0; i < 70; i++) step();

    // Intermediate codes during a hold are dropped.
    io.display = 3'd4;
    step();
    step();
    check("win_code", 8'(io.msg_code), 8'h04);
    pulses = 0;
    io.display = 3'd6;
    for (int i = 0; i < 4; i++) step();
    io.display = 3'd0;
    for (int i = 0; i < 16; i++) step();
    check("drop_pulses", 8'(pulses), 8'h01);
    check("drop_code", 8'(io.msg_code), 8'h00);

    // Lamp test in the blink-off phase, then resume.
    io.display = 3'd3;
    step();
    step();
    for (int i = 0; i < 38; i++) step();
    check("blink_off_an", 8'(io.an), 8'h00);
    io.lamp_test = 1'b1;
    for (int i = 0; i < 5; i++) step();
    io.lamp_test = 1'b0;
    for (int i = 0; i < 60; i++) step();

    // Reset in the middle of a hold on the error code.
    io.display = 3'd7;
    step();
    step();
    check("err_code", 8'(io.msg_code), 8'h07);
    step();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_seg", 8'(io.seg), 8'h00);
    check("mid_rst_an", 8'(io.an), 8'h00);
    check("mid_rst_code", 8'(io.msg_code), 8'h00);
    check("mid_rst_upd", 8'(io.msg_update), 8'h00);
    model_reset();
    io.display = 3'd0;
    #2 rst = 1'b1;
    step();
    check("rerun_an", 8'(io.an), 8'h01);
    check("rerun_seg", 8'(io.seg), 8'h79);
    for (int i = 0; i < 16; i++) step();

    // Random codes and occasional lamp test.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        io.display = 3'($urandom_range(0, 7));
      io.lamp_test = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
